// File: rtl/muldiv_sequencer.sv
// M-extension sequencer: issues MUL*/DIV*/REM* ops to external units,
// short-circuits special divides and returns a tagged result.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mul_start,
    output logic [32:0] mul_a,
    output logic [32:0] mul_b,
    input  logic        mul_done,
    input  logic [65:0] mul_product,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, MUL_WAIT, DIV_WAIT, RESP, DRAIN
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        first;
    logic        accept, div_zero, div_ovf, special, cap;
    logic [31:0] special_data, mul_res, div_res;
    logic        prod_unused;

    assign prod_unused = ^mul_product[65:64];

    assign accept = req_valid & req_ready;

    assign div_zero = (req_rs2 == 32'd0);
    assign div_ovf  = ~req_funct3[0] &
                      (req_rs1 == 32'h8000_0000) &
                      (req_rs2 == 32'hFFFF_FFFF);
    assign special  = req_funct3[2] & (div_zero | div_ovf);

    // REM/REMU pick the remainder, DIV/DIVU the quotient
    always_comb begin
        special_data = 32'd0;
        if (req_funct3[1])
            special_data = div_zero ? req_rs1 : 32'd0;
        else
            special_data = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    assign mul_res = (f3[1:0] == 2'b00) ? mul_product[31:0]
                                        : mul_product[63:32];
    assign div_res = f3[1] ? div_remainder : div_quotient;

    assign mul_a = (f3[1:0] == 2'b11) ? {1'b0, rs1} : {rs1[31], rs1};
    assign mul_b = f3[1] ? {1'b0, rs2} : {rs2[31], rs2};

    assign div_signed   = f3[2] & ~f3[0];
    assign div_dividend = rs1;
    assign div_divisor  = rs2;

    assign req_ready  = (state == IDLE) & ~flush;
    assign busy       = (state != IDLE);
    assign mul_start  = (state == MUL_WAIT) & first;
    assign div_start  = (state == DIV_WAIT) & first;
    assign resp_valid = (state == RESP);
    assign resp_data  = data;
    assign resp_rd    = rd;

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_funct3[2])
                        state_nx = MUL_WAIT;
                    else if (special)
                        state_nx = RESP;
                    else
                        state_nx = DIV_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mul_done) begin
                    state_nx = flush ? IDLE : RESP;
                    cap      = ~flush;
                end else if (flush) begin
                    state_nx = DRAIN;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    state_nx = flush ? IDLE : RESP;
                    cap      = ~flush;
                end else if (flush) begin
                    state_nx = DRAIN;
                end
            end
            RESP: begin
                if (flush || resp_ready)
                    state_nx = IDLE;
            end
            DRAIN: begin
                if (f3[2] ? div_done : mul_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f3    <= 3'd0;
            rs1   <= 32'd0;
            rs2   <= 32'd0;
            rd    <= 5'd0;
            data  <= 32'd0;
            first <= 1'b0;
        end else begin
            state <= state_nx;
            first <= accept & ~special;
            if (accept) begin
                f3  <= req_funct3;
                rs1 <= req_rs1;
                rs2 <= req_rs2;
                rd  <= req_rd;
                if (special)
                    data <= special_data;
            end
            if (cap)
                data <= f3[2] ? div_res : mul_res;
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have rst  input  1  reset; rst is synchronous, active-high.
REQ-003 SHALL have req_valid  input  1  pipeline presents an M-extension op.
REQ-004 SHALL have req_ready  output  1  sequencer accepts the op this cycle.
REQ-005 SHALL have req_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have req_rs1, req_rs2  input  32 each  source operands.
REQ-007 SHALL have req_rd  input  5  destination tag, returned unchanged.
REQ-008 SHALL have flush  input  1  kill the in-flight op.
REQ-009 SHALL have mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 SHALL have mul_a, mul_b  output  33 each  sign/zero-extended operands.
REQ-011 SHALL have mul_done  input  1; mul_product  input  66  signed product.
REQ-012 SHALL have div_start  output  1; div_signed  output  1; div_dividend, div_divisor  output  32 each.
REQ-013 SHALL have div_done  input  1; div_quotient, div_remainder  input  32 each.
REQ-014 SHALL have resp_valid  output  1; resp_ready  input  1; resp_data  output  32; resp_rd  output  5.
REQ-015 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, MUL_WAIT, DIV_WAIT, RESP, DRAIN.
REQ-017 req_ready SHALL be 1 only in IDLE with flush=0; accept = req_valid & req_ready.
REQ-018 On accept, SHALL latch funct3, rs1, rs2 and rd.
REQ-019 On accept of funct3[2]=0, SHALL go to MUL_WAIT; on accept of funct3[2]=1, SHALL go to DIV_WAIT, except for special divides (REQ-024), which go to RESP.
REQ-020 mul_start / div_start SHALL be 1 only in the first cycle after entering MUL_WAIT / DIV_WAIT; operand outputs SHALL stay stable until done.
REQ-021 mul_a SHALL be {rs1[31], rs1} for MUL/MULH/MULHSU and {1'b0, rs1} for MULHU; mul_b SHALL be {rs2[31], rs2} for MUL/MULH and {1'b0, rs2} otherwise.
REQ-022 Result SHALL be mul_product[31:0] for MUL and mul_product[63:32] for MULH/MULHSU/MULHU.
REQ-023 div_signed SHALL be 1 for DIV/REM; the result SHALL be div_quotient for DIV/DIVU and div_remainder for REM/REMU.
REQ-024 Special divides SHALL bypass the divider (no div_start) and enter RESP the cycle after accept:
- divisor 0: quotient 0xFFFFFFFF, remainder rs1.
- signed, rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-025 In MUL_WAIT / DIV_WAIT, SHALL capture the result on the cycle mul_done / div_done=1, then go to RESP; resp_valid SHALL be high the following cycle.
REQ-026 Minimum latency SHALL be one cycle from done to resp_valid; a done in the start-pulse cycle SHALL be honoured.
REQ-027 In RESP, resp_valid SHALL stay 1 with resp_data and resp_rd stable until resp_ready=1, then go to IDLE; a new accept is possible the next cycle.
REQ-028 done inputs SHALL be ignored in IDLE and RESP.
REQ-029 flush in IDLE SHALL block acceptance.
REQ-030 flush in RESP SHALL drop the response: go to IDLE, resp_valid=0 next cycle.
REQ-031 flush in MUL_WAIT / DIV_WAIT with the matching done=0 SHALL go to DRAIN; with done=1 the same cycle it SHALL go to IDLE and discard the result.
REQ-032 DRAIN SHALL wait for the pending unit's done, then go to IDLE with no response; flush in DRAIN has no extra effect.
REQ-033 flush on a start-pulse cycle SHALL still let the pulse issue, then DRAIN.

Reset
REQ-034 When rst=1 at a clock edge, SHALL enter IDLE and clear all latched fields; rst overrides flush and done.
REQ-035 After reset, outputs SHALL be: req_ready=1 (flush=0), busy=0, mul_start=0, div_start=0, resp_valid=0, resp_data=0, resp_rd=0, mul_a=mul_b=0, div_*=0.
REQ-036 rst mid-operation SHALL abandon the op with no response; unit done pulses arriving afterwards SHALL be ignored in IDLE.

Verification
REQ-037 MULH rs1=0xFFFFFFFF, rs2=0x00000002, product model latency 4, resp_ready=1 -> one mul_start; mul_a=0x1FFFFFFFF; resp_data=0xFFFFFFFF, resp_rd echoed, resp_valid one cycle after mul_done.
REQ-038 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> no div_start; resp_valid the cycle after accept; resp_data=0x80000000. REMU rs2=0, rs1=0x1234 -> resp_data=0x1234.
REQ-039 DIVU 100/7 with resp_ready held 0 for 3 cycles -> resp_valid and resp_data=14 stable throughout; req_ready=0 until the cycle after the handshake.
REQ-040 flush 2 cycles into DIV_WAIT, div_done 5 cycles later -> DRAIN, no resp_valid, req_ready=1 the cycle after div_done.
REQ-041 flush in the same cycle as mul_done -> no resp_valid; next op accepted the following cycle.
REQ-042 rst asserted in MUL_WAIT, then a stray mul_done -> IDLE, busy=0, resp_valid stays 0.
